// File: rtl/had_satd_acc.sv
// 4x4 Hadamard SATD pipeline: residual + horizontal transform, vertical transform,
// per-block normalised SATD, then a saturating accumulator over NUM_BLK blocks.
module had_satd_acc #(
    parameter int BIT_DEPTH = 8,
    parameter int NUM_BLK   = 4,
    parameter int SUM_W     = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [16*BIT_DEPTH-1:0]  cur_blk,
    input  logic [16*BIT_DEPTH-1:0]  ref_blk,
    output logic                     blk_valid,
    output logic [BIT_DEPTH+4:0]     blk_satd,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SUM_W-1:0]         satd_sum
);
    localparam int H_W   = BIT_DEPTH + 3;
    localparam int V_W   = BIT_DEPTH + 5;
    localparam int B_W   = BIT_DEPTH + 5;
    localparam int S_W   = BIT_DEPTH + 10;
    localparam int ACC_W = ((SUM_W > B_W) ? SUM_W : B_W) + 1;
    localparam int CNT_W = (NUM_BLK > 1) ? $clog2(NUM_BLK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BLK - 1);
    localparam logic [SUM_W-1:0] SUM_MAX  = '1;

    logic stall;
    logic s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d, s3_vld_q, s3_vld_d;
    logic [B_W-1:0]   blk_satd_q, blk_satd_d, satd_c;
    logic [SUM_W-1:0] acc_q, acc_d, satd_sum_q, satd_sum_d, sum_sat;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;

    logic signed [H_W-1:0] dx [4][4];
    logic signed [H_W-1:0] h_d [4][4];
    logic signed [H_W-1:0] h_q [4][4];
    logic signed [V_W-1:0] vx [4][4];
    logic signed [V_W-1:0] v_d [4][4];
    logic signed [V_W-1:0] v_q [4][4];

    assign stall     = ~en | (out_valid_q & ~out_ready);
    assign in_ready  = ~stall;
    assign blk_valid = s3_vld_q & ~stall;
    assign blk_satd  = blk_satd_q;
    assign out_valid = out_valid_q;
    assign satd_sum  = satd_sum_q;

    function automatic logic [V_W-1:0] mag_of(input logic signed [V_W-1:0] x);
        return x[V_W-1] ? -x : x;
    endfunction

    // Stage 1: residuals and per-row butterflies (0,2)(1,3) then (0,1)(2,3).
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                dx[r][c] = H_W'($signed({1'b0, cur_blk[(4*r+c)*BIT_DEPTH +: BIT_DEPTH]}))
                         - H_W'($signed({1'b0, ref_blk[(4*r+c)*BIT_DEPTH +: BIT_DEPTH]}));
            end
            h_d[r][0] = (dx[r][0] + dx[r][2]) + (dx[r][1] + dx[r][3]);
            h_d[r][1] = (dx[r][0] + dx[r][2]) - (dx[r][1] + dx[r][3]);
            h_d[r][2] = (dx[r][0] - dx[r][2]) + (dx[r][1] - dx[r][3]);
            h_d[r][3] = (dx[r][0] - dx[r][2]) - (dx[r][1] - dx[r][3]);
        end
    end

    // Stage 2: same butterflies down each column.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) vx[r][c] = V_W'(h_q[r][c]);
            v_d[0][c] = (vx[0][c] + vx[2][c]) + (vx[1][c] + vx[3][c]);
            v_d[1][c] = (vx[0][c] + vx[2][c]) - (vx[1][c] + vx[3][c]);
            v_d[2][c] = (vx[0][c] - vx[2][c]) + (vx[1][c] - vx[3][c]);
            v_d[3][c] = (vx[0][c] - vx[2][c]) - (vx[1][c] - vx[3][c]);
        end
    end

    // Stage 3: DC coefficient is weighted by 1/4 before halving the total.
    logic [S_W-1:0] s_sum, dc_mag, satd_full;
    always_comb begin
        s_sum = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s_sum = s_sum + S_W'(mag_of(v_q[r][c]));
        dc_mag    = S_W'(mag_of(v_q[0][0]));
        satd_full = s_sum - dc_mag + (dc_mag >> 2) + S_W'(1);
        satd_c    = B_W'(satd_full >> 1);
    end

    logic [ACC_W-1:0] sum_wide;
    assign sum_wide = ACC_W'(acc_q) + ACC_W'(blk_satd_q);
    assign sum_sat  = (sum_wide > ACC_W'(SUM_MAX)) ? SUM_MAX : SUM_W'(sum_wide);

    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    always_comb begin
        s1_vld_d    = s1_vld_q;
        s2_vld_d    = s2_vld_q;
        s3_vld_d    = s3_vld_q;
        blk_satd_d  = blk_satd_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        satd_sum_d  = satd_sum_q;
        if (clear) begin
            s1_vld_d    = 1'b0;
            s2_vld_d    = 1'b0;
            s3_vld_d    = 1'b0;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else if (!stall) begin
            s1_vld_d = in_valid;
            s2_vld_d = s1_vld_q;
            s3_vld_d = s2_vld_q;
            if (s2_vld_q) blk_satd_d = satd_c;
            // Not stalled means any pending result is taken on this edge.
            out_valid_d = 1'b0;
            if (s3_vld_q) begin
                if (cnt_q == CNT_LAST) begin
                    satd_sum_d  = sum_sat;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
                end else begin
                    acc_d = sum_sat;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q    <= 1'b0;
            s2_vld_q    <= 1'b0;
            s3_vld_q    <= 1'b0;
            blk_satd_q  <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            satd_sum_q  <= '0;
        end else begin
            s1_vld_q    <= s1_vld_d;
            s2_vld_q    <= s2_vld_d;
            s3_vld_q    <= s3_vld_d;
            blk_satd_q  <= blk_satd_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            satd_sum_q  <= satd_sum_d;
        end
    end

    // NOTE: coefficient registers are qualified by the valid bits, so they need no reset.
    always_ff @(posedge clk) begin
        if (!stall) begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end
endmodule

// File: tb/tb_had_satd_acc.sv
// Scoreboard bench for had_satd_acc: matrix-product SATD model, decoupled monitor,
// second instance with SUM_W=10 to exercise saturation.
module tb_had_satd_acc;
    localparam int BD = 8;
    localparam int NB = 4;
    localparam int PW = 16 * BD;
    typedef logic [PW-1:0] blk_t;

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    blk_t cur_blk = '0, ref_blk = '0;
    logic in_ready, blk_valid, out_valid, in_ready2, blk_valid2, out_valid2;
    logic [BD+4:0] blk_satd, blk_satd2;
    logic [19:0]   satd_sum;
    logic [9:0]    satd_sum2;

    had_satd_acc #(.BIT_DEPTH(BD), .NUM_BLK(NB), .SUM_W(20)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready), .cur_blk(cur_blk), .ref_blk(ref_blk), .blk_valid(blk_valid),
        .blk_satd(blk_satd), .out_valid(out_valid), .out_ready(out_ready), .satd_sum(satd_sum));

    had_satd_acc #(.BIT_DEPTH(BD), .NUM_BLK(NB), .SUM_W(10)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready2), .cur_blk(cur_blk), .ref_blk(ref_blk), .blk_valid(blk_valid2),
        .blk_satd(blk_satd2), .out_valid(out_valid2), .out_ready(out_ready), .satd_sum(satd_sum2));

    always #5 clk = ~clk;

    int n_checks = 0, n_errs = 0;
    int blk_q[$], blk_q2[$], sum_q[$], sum_q2[$];
    int acc_a = 0, acc_b = 0, cnt_m = 0;
    int rdy_mode = 0;
    bit en_rand = 1'b0;
    int hold_cnt = 0;
    bit last_acc;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_errs++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference: coef = H * D * H^T with the 4-point Hadamard matrix.
    function automatic int ref_satd(input blk_t c, input blk_t r);
        int h[4][4] = '{'{1, 1, 1, 1}, '{1, -1, 1, -1}, '{1, 1, -1, -1}, '{1, -1, -1, 1}};
        int d[4][4], t[4][4];
        int s = 0, dc = 0, co;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                d[i][j] = int'(c[(4*i+j)*BD +: BD]) - int'(r[(4*i+j)*BD +: BD]);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                t[i][j] = 0;
                for (int k = 0; k < 4; k++) t[i][j] += d[i][k] * h[j][k];
            end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                co = 0;
                for (int k = 0; k < 4; k++) co += h[i][k] * t[k][j];
                if (co < 0) co = -co;
                s += co;
                if (i == 0 && j == 0) dc = co;
            end
        return (s - dc + dc / 4 + 1) / 2;
    endfunction

    task automatic model_push(input blk_t c, input blk_t r);
        int v = ref_satd(c, r);
        blk_q.push_back(v);
        blk_q2.push_back(v);
        acc_a = (acc_a + v > (1 << 20) - 1) ? (1 << 20) - 1 : acc_a + v;
        acc_b = (acc_b + v > 1023) ? 1023 : acc_b + v;
        cnt_m++;
        if (cnt_m == NB) begin
            sum_q.push_back(acc_a);
            sum_q2.push_back(acc_b);
            acc_a = 0;
            acc_b = 0;
            cnt_m = 0;
        end
    endtask

    task automatic model_flush();
        blk_q.delete(); blk_q2.delete(); sum_q.delete(); sum_q2.delete();
        acc_a = 0; acc_b = 0; cnt_m = 0;
    endtask

    function automatic blk_t rand_blk();
        blk_t b;
        for (int i = 0; i < PW / 32; i++) b[i*32 +: 32] = $urandom();
        return b;
    endfunction

    function automatic blk_t fill(input int v);
        blk_t b;
        for (int i = 0; i < 16; i++) b[i*BD +: BD] = BD'(v);
        return b;
    endfunction

    // Inputs change on the falling edge; acceptance is decided just before the rising edge.
    task automatic drive_cycle(input logic v, input logic clr, input blk_t c, input blk_t r);
        @(negedge clk);
        in_valid = v;
        clear    = clr;
        cur_blk  = c;
        ref_blk  = r;
        en       = en_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (hold_cnt >= 5);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        #2;
        if (rdy_mode == 1) begin
            if (out_valid && !out_ready) begin
                check("stall_in_ready", in_ready, 0);
                hold_cnt++;
            end else if (out_valid) begin
                hold_cnt = 0;
            end
        end
        last_acc = v && in_ready && !clr;
        if (clr) model_flush();
        else if (last_acc) model_push(c, r);
    endtask

    task automatic idle();
        drive_cycle(1'b0, 1'b0, '0, '0);
    endtask

    task automatic send_blk(input blk_t c, input blk_t r);
        for (int i = 0; i < 40; i++) begin
            drive_cycle(1'b1, 1'b0, c, r);
            if (last_acc) return;
        end
        flag("send_timeout");
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        clear    = 1'b0;
        en       = 1'b1;
        model_flush();
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_blk_valid", blk_valid, 0);
        check("rst_satd_sum", satd_sum, 0);
        check("rst_blk_satd", blk_satd, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_satd_sum_sat", satd_sum2, 0);
        @(negedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an output.
    bit prev_hold = 1'b0;
    logic [19:0] prev_sum;
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev_hold = 1'b0;
            end else begin
                if (blk_valid) begin
                    if (blk_q.size() == 0) flag("blk_unexpected");
                    else check("blk_satd", blk_satd, blk_q.pop_front());
                end
                if (blk_valid2) begin
                    if (blk_q2.size() == 0) flag("blk_unexpected_sat");
                    else check("blk_satd_sat", blk_satd2, blk_q2.pop_front());
                end
                if (prev_hold) begin
                    check("hold_out_valid", out_valid, 1);
                    check("hold_satd_sum", satd_sum, prev_sum);
                end
                if (out_valid && out_ready && en) begin
                    if (sum_q.size() == 0) flag("sum_unexpected");
                    else check("satd_sum", satd_sum, sum_q.pop_front());
                end
                if (out_valid2 && out_ready && en) begin
                    if (sum_q2.size() == 0) flag("sum_unexpected_sat");
                    else check("satd_sum_sat", satd_sum2, sum_q2.pop_front());
                end
                prev_hold = out_valid && !out_ready && !clear;
                prev_sum  = satd_sum;
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        blk_t b, r;
        do_reset();

        // Identical blocks: zero SATD, result three cycles after the last accept.
        for (int i = 0; i < 4; i++) begin
            b = rand_blk();
            send_blk(b, b);
        end
        repeat (3) idle();
        check("latency_early", out_valid, 0);
        idle();
        check("latency_out_valid", out_valid, 1);

        // Full-scale DC residual: 510 per block, 2040 total, 1023 when saturated.
        for (int i = 0; i < 4; i++) send_blk(fill(255), fill(0));

        // Single-pixel residual of 10: 76 per block.
        for (int i = 0; i < 4; i++) begin
            r = rand_blk();
            r[BD-1:0] = BD'($urandom_range(0, 245));
            b = r;
            b[BD-1:0] = r[BD-1:0] + BD'(10);
            send_blk(b, r);
        end
        repeat (5) idle();

        // Consumer holds off each result for five cycles while blocks stream in.
        rdy_mode = 1;
        hold_cnt = 0;
        for (int i = 0; i < 8; i++) send_blk(rand_blk(), rand_blk());
        repeat (12) idle();
        rdy_mode = 0;

        // Clear after two blocks discards the partial sum.
        for (int i = 0; i < 2; i++) send_blk(fill(255), fill(0));
        drive_cycle(1'b1, 1'b1, fill(255), fill(0));
        repeat (6) idle();
        check("clear_no_out_valid", out_valid, 0);
        for (int i = 0; i < 4; i++) send_blk(fill(255), fill(0));
        repeat (5) idle();

        // Reset after two blocks discards the partial sum.
        for (int i = 0; i < 2; i++) send_blk(fill(255), fill(0));
        do_reset();
        repeat (4) idle();
        check("reset_no_out_valid", out_valid, 0);
        for (int i = 0; i < 4; i++) send_blk(fill(255), fill(0));

        // Random traffic with random enable, back-pressure and occasional clear.
        en_rand  = 1'b1;
        rdy_mode = 2;
        for (int i = 0; i < 400; i++) begin
            r = rand_blk();
            if ($urandom_range(0, 1) != 0) begin
                b = r;
                for (int p = 0; p < 16; p++)
                    b[p*BD +: BD] = BD'($urandom_range(0, 255) & 32'h3);
                b = b ^ r;
            end else begin
                b = rand_blk();
            end
            drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0), b, r);
        end

        en_rand  = 1'b0;
        rdy_mode = 0;
        repeat (10) idle();
        check("drain_blk_q", blk_q.size(), 0);
        check("drain_sum_q", sum_q.size(), 0);
        check("drain_sum_q_sat", sum_q2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
